// File: rtl/jtroc_sndif_pkg.sv
// Shared helpers for the Roc'n Rope sound interface: the timer bit-select that
// feeds AY port B.
package jtroc_sndif_pkg;

  localparam int TIMER_W_MIN = 10;

  // Bits picked off the free-running counter to form the AY port B nibble
  function automatic logic [3:0] timer_sel(input logic [9:0] cnt);
    return {cnt[9], cnt[8], cnt[7], cnt[4]};
  endfunction

endpackage

// File: rtl/jtroc_sndtimer.sv
// Free-running sound timer; presents a registered 4-bit slice of the count.
module jtroc_sndtimer
  import jtroc_sndif_pkg::*;
#(
  parameter int TIMER_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timer_cen,
  output logic [3:0] timer_dout
);

  localparam logic [TIMER_W-1:0] CNT_ONE = TIMER_W'(1);

  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [3:0]         dout_q;

  always_comb begin
    cnt_d = cnt_q;
    if (timer_cen) cnt_d = cnt_q + CNT_ONE;
  end

  // The output slice is taken from the next count so it moves on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= timer_sel(cnt_d[9:0]);
    end
  end

  assign timer_dout = dout_q;

endmodule

// File: rtl/jtroc_sndif.sv
// Main-to-sound CPU interface: command latch with overrun detection, edge
// triggered sound IRQ, and the AY port B timer.
module jtroc_sndif #(
  parameter int         TIMER_W    = 10,
  parameter logic [7:0] LATCH_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       main_cen,
  input  logic [7:0] main_dout,
  input  logic       snd_data_cs,
  input  logic       snd_on_cs,
  input  logic       snd_cen,
  input  logic       latch_rd,
  input  logic       int_ack,
  input  logic       timer_cen,
  output logic [7:0] latch_dout,
  output logic       snd_irq_n,
  output logic [3:0] timer_dout,
  output logic       latch_full,
  output logic       overrun
);

  localparam logic LATCH_EMPTY = 1'b0;
  localparam logic LATCH_FULL  = 1'b1;
  localparam logic IRQ_IDLE    = 1'b0;
  localparam logic IRQ_PEND    = 1'b1;

  logic       latch_st_q, latch_st_d;
  logic [7:0] data_q;
  logic       full_q;
  logic       overrun_q, overrun_d;
  logic       on_q;
  logic       irq_st_q, irq_st_d;
  logic       irq_n_q;

  logic wr, rd, on_wr, trig, ack;

  assign wr    = main_cen & snd_data_cs;
  assign rd    = latch_rd & snd_cen;
  assign on_wr = main_cen & snd_on_cs;
  assign trig  = on_wr & main_dout[0] & ~on_q;
  assign ack   = int_ack & snd_cen;

  // A simultaneous read consumes the old data, so it does not count as overrun
  always_comb begin
    latch_st_d = latch_st_q;
    overrun_d  = overrun_q;
    case (latch_st_q)
      LATCH_EMPTY: if (wr) latch_st_d = LATCH_FULL;
      LATCH_FULL: begin
        if (wr) begin
          if (!rd) overrun_d = 1'b1;
        end else if (rd) begin
          latch_st_d = LATCH_EMPTY;
        end
      end
      default: latch_st_d = LATCH_EMPTY;
    endcase
  end

  // Trigger wins over a same-cycle acknowledge so no request is lost
  always_comb begin
    irq_st_d = irq_st_q;
    if (trig)     irq_st_d = IRQ_PEND;
    else if (ack) irq_st_d = IRQ_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      latch_st_q <= LATCH_EMPTY;
      data_q     <= LATCH_INIT;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      on_q       <= 1'b0;
      irq_st_q   <= IRQ_IDLE;
      irq_n_q    <= 1'b1;
    end else begin
      latch_st_q <= latch_st_d;
      if (wr) data_q <= main_dout;
      full_q     <= (latch_st_d == LATCH_FULL);
      overrun_q  <= overrun_d;
      if (on_wr) on_q <= main_dout[0];
      irq_st_q   <= irq_st_d;
      irq_n_q    <= (irq_st_d != IRQ_PEND);
    end
  end

  assign latch_dout = data_q;
  assign latch_full = full_q;
  assign overrun    = overrun_q;
  assign snd_irq_n  = irq_n_q;

  jtroc_sndtimer #(
    .TIMER_W(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .timer_cen (timer_cen),
    .timer_dout(timer_dout)
  );

endmodule

// File: tb/tb_jtroc_sndif.sv
// Directed bench for jtroc_sndif: latch handshake, IRQ edge trigger, reset
// priority and timer slice, with hand-computed expectations.
module tb_jtroc_sndif;

  logic       clk = 1'b0;
  logic       rst;
  logic       mainCen;
  logic [7:0] mainDout;
  logic       sndDataCs;
  logic       sndOnCs;
  logic       sndCen;
  logic       latchRd;
  logic       intAck;
  logic       timerCen;
  logic [7:0] latchDout;
  logic       sndIrqN;
  logic [3:0] timerDout;
  logic       latchFull;
  logic       overrun;

  int passCount = 0;
  int checkCount = 0;

  always #21 clk = ~clk;

  jtroc_sndif #(
    .TIMER_W   (10),
    .LATCH_INIT(8'h00)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .main_cen   (mainCen),
    .main_dout  (mainDout),
    .snd_data_cs(sndDataCs),
    .snd_on_cs  (sndOnCs),
    .snd_cen    (sndCen),
    .latch_rd   (latchRd),
    .int_ack    (intAck),
    .timer_cen  (timerCen),
    .latch_dout (latchDout),
    .snd_irq_n  (sndIrqN),
    .timer_dout (timerDout),
    .latch_full (latchFull),
    .overrun    (overrun)
  );

  // Advance one clock and settle just past the edge before checking
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    mainCen   = 1'b0;
    mainDout  = 8'h00;
    sndDataCs = 1'b0;
    sndOnCs   = 1'b0;
    sndCen    = 1'b0;
    latchRd   = 1'b0;
    intAck    = 1'b0;
    timerCen  = 1'b0;
  endtask

  // Drive one cycle of strobes, then return inputs to idle
  task automatic applyStimulus(input logic wrData, input logic wrOn, input logic [7:0] d,
                               input logic rd, input logic ack);
    mainCen   = wrData | wrOn;
    sndDataCs = wrData;
    sndOnCs   = wrOn;
    mainDout  = d;
    latchRd   = rd;
    intAck    = ack;
    sndCen    = rd | ack;
    tick();
    idleInputs();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    tick(2);
    checkOutput("rst_dout", latchDout, 8'h00);
    checkOutput("rst_full", {7'd0, latchFull}, 8'd0);
    checkOutput("rst_ovr", {7'd0, overrun}, 8'd0);
    checkOutput("rst_irq", {7'd0, sndIrqN}, 8'd1);
    checkOutput("rst_timer", {4'd0, timerDout}, 8'd0);
    rst = 1'b0;
    tick();

    // Scenario 1: single write then read
    applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
    checkOutput("s1_dout", latchDout, 8'hA5);
    checkOutput("s1_full", {7'd0, latchFull}, 8'd1);
    sndDataCs = 1'b1; mainDout = 8'hFF;
    tick();
    idleInputs();
    checkOutput("s1_nocen_dout", latchDout, 8'hA5);
    latchRd = 1'b1;
    tick();
    idleInputs();
    checkOutput("s1_nosndcen_full", {7'd0, latchFull}, 8'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("s1_rd_full", {7'd0, latchFull}, 8'd0);
    checkOutput("s1_rd_ovr", {7'd0, overrun}, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("s1_rdempty_full", {7'd0, latchFull}, 8'd0);
    checkOutput("s1_rdempty_dout", latchDout, 8'hA5);

    // Scenario 2: back-to-back writes overrun
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
    checkOutput("s2_dout", latchDout, 8'h22);
    checkOutput("s2_ovr", {7'd0, overrun}, 8'd1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("s2_rd_full", {7'd0, latchFull}, 8'd0);
    checkOutput("s2_ovr_sticky", {7'd0, overrun}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("s2_ovr_rst", {7'd0, overrun}, 8'd0);

    // Scenario 3: write and read in the same cycle while full
    applyStimulus(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
    mainCen = 1'b1; sndDataCs = 1'b1; mainDout = 8'h33;
    latchRd = 1'b1; sndCen = 1'b1;
    checkOutput("s3_rd_old", latchDout, 8'h44);
    tick();
    idleInputs();
    checkOutput("s3_dout", latchDout, 8'h33);
    checkOutput("s3_full", {7'd0, latchFull}, 8'd1);
    checkOutput("s3_ovr", {7'd0, overrun}, 8'd0);

    // Scenario 4: IRQ edge trigger, acknowledge, and collision
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("s4_on0", {7'd0, sndIrqN}, 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    checkOutput("s4_on1", {7'd0, sndIrqN}, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    checkOutput("s4_on11", {7'd0, sndIrqN}, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("s4_ack", {7'd0, sndIrqN}, 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    checkOutput("s4_noretrig", {7'd0, sndIrqN}, 8'd1);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 1'b1);
    checkOutput("s4_trig_ack", {7'd0, sndIrqN}, 8'd0);

    // Scenario 5: reset while pending and full, reset beats a write strobe
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    checkOutput("s5_pre_irq", {7'd0, sndIrqN}, 8'd0);
    checkOutput("s5_pre_full", {7'd0, latchFull}, 8'd1);
    rst = 1'b1;
    mainCen = 1'b1; sndDataCs = 1'b1; mainDout = 8'h77;
    tick();
    rst = 1'b0;
    idleInputs();
    checkOutput("s5_irq", {7'd0, sndIrqN}, 8'd1);
    checkOutput("s5_full", {7'd0, latchFull}, 8'd0);
    checkOutput("s5_dout", latchDout, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
    checkOutput("s5_retrig", {7'd0, sndIrqN}, 8'd0);

    // Scenario 6: timer slice and wrap
    checkOutput("s6_start", {4'd0, timerDout}, 8'h0);
    timerCen = 1'b1;
    tick(16);
    timerCen = 1'b0;
    checkOutput("s6_16", {4'd0, timerDout}, 8'h1);
    tick(3);
    checkOutput("s6_hold", {4'd0, timerDout}, 8'h1);
    timerCen = 1'b1;
    tick(112);
    timerCen = 1'b0;
    checkOutput("s6_128", {4'd0, timerDout}, 8'h2);
    timerCen = 1'b1;
    tick(895);
    timerCen = 1'b0;
    checkOutput("s6_1023", {4'd0, timerDout}, 8'hF);
    timerCen = 1'b1;
    tick();
    timerCen = 1'b0;
    checkOutput("s6_wrap", {4'd0, timerDout}, 8'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
